// File: rtl/issue_buffer.sv
// Dual-ported in-order issue queue between decode and execute: accepts up to two
// entries per cycle and presents the two oldest, pairing them only when legal.
module issue_buffer #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PAYLOAD_W = 96
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid0,
  input  logic                 in_valid1,
  input  logic [PAYLOAD_W-1:0] in_data0,
  input  logic [PAYLOAD_W-1:0] in_data1,
  output logic                 in_ready,
  input  logic                 flush,
  input  logic                 stall,
  output logic                 out_valid0,
  output logic                 out_valid1,
  output logic [PAYLOAD_W-1:0] out_data0,
  output logic [PAYLOAD_W-1:0] out_data1
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PAYLOAD_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic             push_ok;
  logic [1:0]       n_push;
  logic [1:0]       n_pop;
  logic             we0, we1;
  logic [PTR_W-1:0] wa0, wa1;
  logic [PTR_W-1:0] rd_ptr_p1;
  logic             raw;
  logic             pair_ok;

  always_comb begin
    in_ready  = (count_q <= CNT_W'(DEPTH - 2));
    push_ok   = in_ready & ~flush;

    // Slot 1 lands directly behind slot 0 when both are valid, else at wr_ptr.
    we0       = push_ok & in_valid0;
    we1       = push_ok & in_valid1;
    wa0       = wr_ptr_q;
    wa1       = wr_ptr_q + PTR_W'(in_valid0);
    n_push    = push_ok ? ({1'b0, in_valid0} + {1'b0, in_valid1}) : 2'd0;

    rd_ptr_p1 = rd_ptr_q + PTR_W'(1);
    out_data0 = mem_q[rd_ptr_q];
    out_data1 = mem_q[rd_ptr_p1];

    // Second slot may not read the head's destination, and at most one
    // non-simple op may issue per cycle.
    raw       = out_data0[5] & (out_data0[4:0] != 5'd0) &
                ((out_data1[10:6] == out_data0[4:0]) | (out_data1[15:11] == out_data0[4:0]));
    pair_ok   = ~raw & (out_data0[16] | out_data1[16]);

    out_valid0 = (count_q >= CNT_W'(1)) & ~flush;
    out_valid1 = (count_q >= CNT_W'(2)) & ~flush & pair_ok;
    n_pop      = stall ? 2'd0 : ({1'b0, out_valid0} + {1'b0, out_valid1});

    rd_ptr_d = rd_ptr_q + PTR_W'(n_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
    count_d  = count_q + CNT_W'(n_push) - CNT_W'(n_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we0) mem_q[wa0] <= in_data0;
    if (we1) mem_q[wa1] <= in_data1;
  end

endmodule

// File: tb/tb_issue_buffer.sv
// Scoreboard bench for issue_buffer: accepted entries are queued in order and
// checked against what the buffer presents and issues each cycle.
module tb_issue_buffer;

  localparam int unsigned DEPTH     = 16;
  localparam int unsigned PAYLOAD_W = 96;
  typedef logic [PAYLOAD_W-1:0] ent_t;

  logic clk = 1'b0;
  logic rst, in_valid0, in_valid1, flush, stall;
  ent_t in_data0, in_data1, out_data0, out_data1;
  logic in_ready, out_valid0, out_valid1;

  int unsigned n_tests  = 0;
  int unsigned n_failed = 0;
  int unsigned n_pushed = 0;
  int unsigned n_issued = 0;
  int unsigned seq      = 0;
  ent_t        exp_q[$];

  always #5 clk = ~clk;

  issue_buffer #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid0(in_valid0), .in_valid1(in_valid1),
    .in_data0(in_data0), .in_data1(in_data1),
    .in_ready(in_ready), .flush(flush), .stall(stall),
    .out_valid0(out_valid0), .out_valid1(out_valid1),
    .out_data0(out_data0), .out_data1(out_data1)
  );

  task automatic check(input string tag, input ent_t got, input ent_t exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ent_t mk(input int unsigned rd, input logic we, input int unsigned rs1,
                              input int unsigned rs2, input logic simple);
    ent_t x;
    x        = '0;
    x[4:0]   = 5'(rd);
    x[5]     = we;
    x[10:6]  = 5'(rs1);
    x[15:11] = 5'(rs2);
    x[16]    = simple;
    x[63:32] = $urandom;
    x[95:64] = seq;
    seq++;
    return x;
  endfunction

  function automatic ent_t rnd();
    return mk($urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 3), 1'($urandom));
  endfunction

  function automatic logic pairable(input ent_t a, input ent_t b);
    logic hazard;
    hazard = a[5] && (a[4:0] != 0) && (b[10:6] == a[4:0] || b[15:11] == a[4:0]);
    return !hazard && (a[16] || b[16]);
  endfunction

  // One clock: drive at negedge, check presented state, then update the scoreboard.
  task automatic step(input logic v0, input logic v1, input ent_t d0, input ent_t d1,
                      input logic fl, input logic st);
    int unsigned sz;
    logic e_ov0, e_ov1, acc;
    ent_t h;
    @(negedge clk);
    in_valid0 = v0; in_valid1 = v1; in_data0 = d0; in_data1 = d1;
    flush = fl; stall = st;
    #1;
    sz    = exp_q.size();
    e_ov0 = (sz >= 1) && !fl;
    e_ov1 = 1'b0;
    if (sz >= 2 && !fl) e_ov1 = pairable(exp_q[0], exp_q[1]);
    acc   = (sz <= DEPTH - 2) && !fl;
    check("in_ready", ent_t'(in_ready), ent_t'(sz <= DEPTH - 2));
    check("out_valid0", ent_t'(out_valid0), ent_t'(e_ov0));
    check("out_valid1", ent_t'(out_valid1), ent_t'(e_ov1));
    if (e_ov0) check("head0", out_data0, exp_q[0]);
    if (e_ov1) check("head1", out_data1, exp_q[1]);
    if (!st && e_ov0) begin h = exp_q.pop_front(); n_issued++; end
    if (!st && e_ov1) begin h = exp_q.pop_front(); n_issued++; end
    if (acc) begin
      if (v0) begin exp_q.push_back(d0); n_pushed++; end
      if (v1) begin exp_q.push_back(d1); n_pushed++; end
    end
    if (fl) exp_q.delete();
    @(posedge clk);
  endtask

  task automatic idle(input logic st);
    step(1'b0, 1'b0, '0, '0, 1'b0, st);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid0 = 1'b0; in_valid1 = 1'b0; flush = 1'b0; stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && exp_q.size() > 0; i++) idle(1'b0);
    check("drain_left", ent_t'(exp_q.size()), '0);
    idle(1'b0);
  endtask

  initial begin
    ent_t a, b;
    rst = 1'b0; in_valid0 = 1'b0; in_valid1 = 1'b0; flush = 1'b0; stall = 1'b0;
    in_data0 = '0; in_data1 = '0;

    do_reset();
    idle(1'b0);

    // Simple head with independent follower dual-issues.
    a = mk(3, 1'b1, 0, 0, 1'b1);
    b = mk(0, 1'b0, 5, 0, 1'b0);
    step(1'b1, 1'b1, a, b, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b0);
    idle(1'b0);

    // RAW on rs2 forces single issue.
    a = mk(4, 1'b1, 0, 0, 1'b1);
    b = mk(0, 1'b0, 0, 4, 1'b1);
    step(1'b1, 1'b1, a, b, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);

    // Two non-simple ops, no hazard: one per cycle.
    a = mk(6, 1'b1, 1, 2, 1'b0);
    b = mk(7, 1'b1, 2, 1, 1'b0);
    step(1'b1, 1'b1, a, b, 1'b0, 1'b0);
    drain();

    // Fill to full under stall; extra pushes refused; then drain in order.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, rnd(), rnd(), 1'b0, 1'b1);
    step(1'b1, 1'b1, rnd(), rnd(), 1'b0, 1'b1);
    step(1'b1, 1'b1, rnd(), rnd(), 1'b0, 1'b1);
    step(1'b0, 1'b1, rnd(), rnd(), 1'b0, 1'b1);
    check("full_count", ent_t'(exp_q.size()), ent_t'(DEPTH));
    drain();

    // Flush at count 5 with stall and valid pushes empties the buffer.
    step(1'b1, 1'b1, rnd(), rnd(), 1'b0, 1'b1);
    step(1'b1, 1'b1, rnd(), rnd(), 1'b0, 1'b1);
    step(1'b1, 1'b0, rnd(), rnd(), 1'b0, 1'b1);
    step(1'b1, 1'b1, rnd(), rnd(), 1'b1, 1'b1);
    idle(1'b0);
    step(1'b0, 1'b1, rnd(), rnd(), 1'b0, 1'b1);
    idle(1'b0);
    drain();

    // Reset mid-operation discards everything.
    step(1'b1, 1'b1, rnd(), rnd(), 1'b0, 1'b1);
    step(1'b1, 1'b1, rnd(), rnd(), 1'b0, 1'b1);
    do_reset();
    idle(1'b0);

    // Random stream with random stall: exercises pointer wrap.
    n_pushed = 0;
    n_issued = 0;
    for (int cyc = 0; cyc < 400 && n_pushed < 40; cyc++)
      step(1'($urandom), 1'($urandom), rnd(), rnd(), 1'b0, ($urandom_range(0, 2) == 0));
    check("stream_pushed_ge40", ent_t'(n_pushed >= 40), ent_t'(1));
    drain();
    check("stream_issued", ent_t'(n_issued), ent_t'(n_pushed));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/issue_buffer.md
ISSUE_BUFFER -- requirements
Module: issue_buffer

Interface
REQ-001 Parameter DEPTH, default 16, entry count; power of two, >= 4.
REQ-002 Parameter PAYLOAD_W, default 96, entry width in bits; >= 17.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid0  input  1  decode slot 0 carries an instruction.
REQ-006 in_valid1  input  1  decode slot 1 carries an instruction, younger than slot 0.
REQ-007 in_data0  input  PAYLOAD_W  slot 0 entry.
REQ-008 in_data1  input  PAYLOAD_W  slot 1 entry.
REQ-009 in_ready  output  1  buffer can accept two entries this cycle.
REQ-010 flush  input  1  branch-mispredict flush; discards all contents.
REQ-011 stall  input  1  downstream (DCache/divider) stall; no pops.
REQ-012 out_valid0  output  1  oldest entry presented for issue.
REQ-013 out_valid1  output  1  second-oldest entry presented for dual issue.
REQ-014 out_data0  output  PAYLOAD_W  oldest entry.
REQ-015 out_data1  output  PAYLOAD_W  second-oldest entry.

Function
REQ-016 Entry metadata at fixed bits: [4:0] rd, [5] rf_we, [10:6] rs1, [15:11] rs2, [16] simple (1 = plain ALU op, inst_type 0x001); remaining bits opaque.
REQ-017 Storage is a circular buffer with rd_ptr, wr_ptr (log2 DEPTH bits, wrap modulo DEPTH) and count (0..DEPTH).
REQ-018 in_ready = (count <= DEPTH-2), from current count only, combinational.
REQ-019 Push when in_ready & !flush: valid slots written in order slot0 then slot1, compacted; in_valid1 alone writes one entry at wr_ptr.
REQ-020 Pushes while in_ready=0 are dropped; upstream holds its data.
REQ-021 out_data0 = entry[rd_ptr], out_data1 = entry[rd_ptr+1 mod DEPTH], combinational (first-word fall-through).
REQ-022 out_valid0 = (count >= 1) & !flush.
REQ-023 out_valid1 = (count >= 2) & !flush & pair_ok.
REQ-024 pair_ok = !RAW & (e0.simple | e1.simple); RAW = e0.rf_we & e0.rd != 0 & (e1.rs1 == e0.rd | e1.rs2 == e0.rd).
REQ-025 Downstream accepts every presented entry when stall=0; pops = stall ? 0 : out_valid0 + out_valid1.
REQ-026 count_next = count + pushes - pops; rd_ptr advances by pops, wr_ptr by pushes, same cycle.
REQ-027 Simultaneous push and pop at count = DEPTH-2 legal; at count = DEPTH-1 push refused even if pops = 2.
REQ-028 Priority: rst > flush > normal; flush with stall still empties buffer.
REQ-029 Flush: count, rd_ptr, wr_ptr cleared next edge; same-cycle pushes discarded.
REQ-030 Entries never reorder; out_data0 always oldest resident entry.
REQ-031 Storage array not reset; contents beyond count are don't-care.

Reset
REQ-032 On rst=1 at clock edge: count=0, rd_ptr=0, wr_ptr=0.
REQ-033 Cycle after reset release: out_valid0=0, out_valid1=0, in_ready=1.
REQ-034 Reset mid-operation discards all entries; no entry issued after reset edge.

Verification
REQ-035 Reset, push A (rd=3,we,simple), B (rs1=5, non-simple) same cycle -> next cycle count=2, out_valid0=1, out_valid1=1, out_data0=A, out_data1=B.
REQ-036 Head A (rd=4,we), next B (rs2=4) -> out_valid1=0; one pop; next cycle out_data0=B.
REQ-037 Two non-simple heads (load, div) with no RAW -> out_valid1=0, single issue per cycle.
REQ-038 DEPTH=16, fill to 14 with stall=1 -> in_ready=1; push 2 -> count=16, in_ready=0; further pushes dropped, count stays 16.
REQ-039 count=5, stall=1, flush=1, pushes valid -> next cycle count=0, out_valid0=0, in_ready=1.
REQ-040 Stream 40 entries with random stall, DEPTH=16 -> pointer wrap exercised; issued sequence equals pushed sequence, none lost or duplicated.
